baccarat_datapath: RTL and testbench
====================================

// Module: baccarat_datapath
// PURPOSE
//  Card datapath of the Baccarat game. Holds the current deal value, six card registers
//  (player 1-3, dealer 1-3), active-low 7-seg displays of all six cards and baccarat scores.
//  Sits under the top level, driven by the game FSM's load strobes; the FSM reads
//  pcard3_out, pscore_out and dscore_out back.
// PARAMETERS
//  none (widths fixed: card 4b, score 4b, segment 7b)
// PORTS
//  slow_clock   in   1  sole clock, all state updates on rising edge
//  reset        in   1  synchronous, active-high reset
//  card_adv     in   1  advance deal value this cycle (replaces separate fast clock)
//  load_pcard1  in   1  capture deal value into player card 1
//  load_pcard2  in   1  capture into player card 2
//  load_pcard3  in   1  capture into player card 3
//  load_dcard1  in   1  capture into dealer card 1
//  load_dcard2  in   1  capture into dealer card 2
//  load_dcard3  in   1  capture into dealer card 3
//  pcard3_out   out  4  raw player card 3 register
//  pscore_out   out  4  player score 0..9
//  dscore_out   out  4  dealer score 0..9
//  HEX0..HEX5   out  7  each 7b, active-low {g,f,e,d,c,b,a}: pcard1,pcard2,pcard3,dcard1,dcard2,dcard3
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (slow_clock / reset).
//  - Reset: new_card=1, all six card regs=0, so HEX0..5=1111111, scores=0, pcard3_out=0.
//  - Deal counter new_card: when card_adv=1 at edge, 1->2->..->13->1 wrap; 0/14/15 -> 1.
//  - Load: at edge with load_x=1, card reg x <= new_card value BEFORE same-edge advance.
//    Any combination of loads may be simultaneous; all capture the same value.
//    Load deasserted -> register holds. Reset has priority over load and advance.
//  - Card value for score: 1..9 -> face value; 0, 10..15 -> 0.
//  - pscore = (val(p1)+val(p2)+val(p3)) mod 10; dscore likewise; sum max 27, 5-bit internal.
//  - Scores and HEX outputs combinational from registers: visible right after load edge.
//  - 7-seg map: 1(A)=0001000 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000 10=1000000 J(11)=1110001 Q(12)=0011000
//    K(13)=0001001; 0,14,15 = 1111111 (blank).
// CONFIGURATION
//  - BACCARAT_REG_SCORES_EN defined: pscore_out/dscore_out registered, updated one
//    slow_clock edge after the load edge, reset to 0.
//  - Not defined (default): scores combinational, zero latency after load.
//  - HEX and pcard3_out behaviour unaffected by the macro.
// STRUCTURE
//  - Package baccarat_pkg: card_t (logic [3:0]), CARD_MIN=1, CARD_MAX=13,
//    SEG_BLANK=7'b1111111, seg code constants, function card_value(card_t).
//  - Sub-module card_seg7: 4b card -> 7b active-low pattern; instantiated six times.
//  - Deal counter, card regs, score adders inline in baccarat_datapath.
// TESTING
//  - Reset, one edge -> all cards 0, HEX0..5=1111111, scores 0, new_card=1.
//  - Load all six with new_card=1 -> every card 1, HEX=0001000; pscore=dscore=3.
//  - Loop: card_adv pulse then load all, 13 times -> card N shows table code; after 13,
//    next advance gives 1 (wrap).
//  - Card 10/J/Q/K in all slots -> scores 0; p=7,8,9 -> pscore=(24 mod 10)=4.
//  - Loads low, several edges -> all cards and HEX hold; card_adv+load same edge -> old value.
//  - Force new_card=15, load all -> cards 15, HEX=1111111, scores 0; reset mid-game clears all.
//  - With BACCARAT_REG_SCORES_EN: score changes one edge after load, not on load edge.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared card types, segment codes and score helpers for the baccarat datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_MIN = 4'd1;
  localparam card_t CARD_MAX = 4'd13;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1110001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

  // Baccarat point value: pips count face value, tens/faces/invalid codes count zero
  function automatic logic [3:0] card_value(input card_t c);
    if (c >= 4'd1 && c <= 4'd9) return c;
    else return 4'd0;
  endfunction

  // Three-card sum is at most 27, so two conditional subtractions reduce it mod 10
  function automatic logic [3:0] score_mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20)      r = sum - 5'd20;
    else if (sum >= 5'd10) r = sum - 5'd10;
    else                   r = sum;
    return r[3:0];
  endfunction

endpackage

// File: rtl/card_seg7.sv
// Card code to active-low 7-segment pattern; 0, 14 and 15 render blank.
// Latency: combinational.
// Backpressure: none.
module card_seg7
  import baccarat_pkg::*;
(
  input  card_t      card,
  output logic [6:0] seg
);

  // Table lookup of the display pattern for each card rank
  always_comb begin
    seg = SEG_BLANK;
    case (card)
      4'd1:    seg = SEG_ACE;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_10;
      4'd11:   seg = SEG_JACK;
      4'd12:   seg = SEG_QUEEN;
      4'd13:   seg = SEG_KING;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: deal counter, six card registers, 7-seg displays and scores.
// Latency: HEX/pcard3_out visible right after the load edge; scores likewise, or one edge later with BACCARAT_REG_SCORES_EN.
// Backpressure: none; load and advance strobes are accepted on every slow_clock edge.
module baccarat_datapath
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       card_adv,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard3_out,
  output logic [3:0] pscore_out,
  output logic [3:0] dscore_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  card_t       new_card;
  card_t       card_r [6];   // 0..2 player cards 1..3, 3..5 dealer cards 1..3
  logic [5:0]  load_vec;
  logic [6:0]  seg [6];
  logic [4:0]  psum, dsum;
  logic [3:0]  pscore_c, dscore_c;

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

  // Deal counter cycles 1..13; any out-of-range value recovers to 1 on the next advance
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      new_card <= CARD_MIN;
    end else if (card_adv) begin
      if (new_card >= CARD_MIN && new_card < CARD_MAX) new_card <= new_card + 4'd1;
      else                                             new_card <= CARD_MIN;
    end
  end

  // Card registers capture the pre-advance deal value on their load strobe
  always_ff @(posedge slow_clock) begin
    for (int i = 0; i < 6; i++) begin
      if (reset)            card_r[i] <= '0;
      else if (load_vec[i]) card_r[i] <= new_card;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_seg
    card_seg7 u_seg (
      .card (card_r[g]),
      .seg  (seg[g])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

  assign pcard3_out = card_r[2];

  // Hand totals, 5 bits wide since three nines reach 27
  always_comb begin
    psum     = {1'b0, card_value(card_r[0])} + {1'b0, card_value(card_r[1])}
             + {1'b0, card_value(card_r[2])};
    dsum     = {1'b0, card_value(card_r[3])} + {1'b0, card_value(card_r[4])}
             + {1'b0, card_value(card_r[5])};
    pscore_c = score_mod10(psum);
    dscore_c = score_mod10(dsum);
  end

`ifdef BACCARAT_REG_SCORES_EN
  logic [3:0] pscore_q, dscore_q;

  // Registered scores trail the card registers by one edge
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      pscore_q <= '0;
      dscore_q <= '0;
    end else begin
      pscore_q <= pscore_c;
      dscore_q <= dscore_c;
    end
  end

  assign pscore_out = pscore_q;
  assign dscore_out = dscore_q;
`else
  assign pscore_out = pscore_c;
  assign dscore_out = dscore_c;
`endif

endmodule

// File: tb/tb_baccarat_datapath.sv
// Directed self-checking bench for baccarat_datapath.
// Latency: scores checked after one extra edge when BACCARAT_REG_SCORES_EN is defined.
// Backpressure: n/a.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b0;
  logic       card_adv = 1'b0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [3:0] pcard3_out, pscore_out, dscore_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_exp [16];
  logic [3:0] tri_score [16];   // (3 * value(n)) mod 10, hand computed

  baccarat_datapath dut (
    .slow_clock  (slow_clock),
    .reset       (reset),
    .card_adv    (card_adv),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .pcard3_out  (pcard3_out),
    .pscore_out  (pscore_out),
    .dscore_out  (dscore_out),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic settle();
`ifdef BACCARAT_REG_SCORES_EN
    tick();
`endif
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_loads(input logic v);
    load_pcard1 = v; load_pcard2 = v; load_pcard3 = v;
    load_dcard1 = v; load_dcard2 = v; load_dcard3 = v;
  endtask

  task automatic load_all();
    set_loads(1'b1);
    tick();
    set_loads(1'b0);
  endtask

  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      card_adv = 1'b1;
      tick();
      card_adv = 1'b0;
    end
  endtask

  task automatic chk_hex_all(input string tag, input logic [6:0] exp);
    chk({tag, "_hex0"}, {1'b0, HEX0}, {1'b0, exp});
    chk({tag, "_hex1"}, {1'b0, HEX1}, {1'b0, exp});
    chk({tag, "_hex2"}, {1'b0, HEX2}, {1'b0, exp});
    chk({tag, "_hex3"}, {1'b0, HEX3}, {1'b0, exp});
    chk({tag, "_hex4"}, {1'b0, HEX4}, {1'b0, exp});
    chk({tag, "_hex5"}, {1'b0, HEX5}, {1'b0, exp});
  endtask

  task automatic chk_scores(input string tag, input logic [3:0] p, input logic [3:0] d);
    chk({tag, "_pscore"}, {4'd0, pscore_out}, {4'd0, p});
    chk({tag, "_dscore"}, {4'd0, dscore_out}, {4'd0, d});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seg_exp[i] = 7'b1111111;
    seg_exp[1]  = 7'b0001000; seg_exp[2]  = 7'b0100100; seg_exp[3]  = 7'b0110000;
    seg_exp[4]  = 7'b0011001; seg_exp[5]  = 7'b0010010; seg_exp[6]  = 7'b0000010;
    seg_exp[7]  = 7'b1111000; seg_exp[8]  = 7'b0000000; seg_exp[9]  = 7'b0010000;
    seg_exp[10] = 7'b1000000; seg_exp[11] = 7'b1110001; seg_exp[12] = 7'b0011000;
    seg_exp[13] = 7'b0001001;
    for (int i = 0; i < 16; i++) tri_score[i] = 4'd0;
    tri_score[1] = 4'd3; tri_score[2] = 4'd6; tri_score[3] = 4'd9;
    tri_score[4] = 4'd2; tri_score[5] = 4'd5; tri_score[6] = 4'd8;
    tri_score[7] = 4'd1; tri_score[8] = 4'd4; tri_score[9] = 4'd7;

    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_hex_all("rst", 7'b1111111);
    chk("rst_pcard3", {4'd0, pcard3_out}, 8'd0);
    chk_scores("rst", 4'd0, 4'd0);
    chk("rst_new_card", {4'd0, dut.new_card}, 8'd1);

    // All six slots take the ace
    load_all();
`ifdef BACCARAT_REG_SCORES_EN
    chk_scores("ace_lat", 4'd0, 4'd0);
`endif
    chk_hex_all("ace", 7'b0001000);
    chk("ace_pcard3", {4'd0, pcard3_out}, 8'd1);
    settle();
    chk_scores("ace", 4'd3, 4'd3);

    // Walk the deal counter through every rank
    for (int n = 2; n <= 13; n++) begin
      advance(1);
      load_all();
      chk($sformatf("walk%0d_hex0", n), {1'b0, HEX0}, {1'b0, seg_exp[n]});
      chk($sformatf("walk%0d_hex5", n), {1'b0, HEX5}, {1'b0, seg_exp[n]});
      chk($sformatf("walk%0d_pcard3", n), {4'd0, pcard3_out}, n[7:0]);
      settle();
      chk_scores($sformatf("walk%0d", n), tri_score[n], tri_score[n]);
    end

    // Wrap 13 -> 1, loaded into player card 1 only
    advance(1);
    load_pcard1 = 1'b1;
    tick();
    load_pcard1 = 1'b0;
    chk("wrap_hex0", {1'b0, HEX0}, {1'b0, 7'b0001000});
    chk("wrap_hex1", {1'b0, HEX1}, {1'b0, 7'b0001001});
    chk("wrap_pcard3", {4'd0, pcard3_out}, 8'd13);
    settle();
    chk_scores("wrap", 4'd1, 4'd0);

    // Hold with no strobes
    tick(); tick(); tick();
    chk("hold_hex0", {1'b0, HEX0}, {1'b0, 7'b0001000});
    chk("hold_hex4", {1'b0, HEX4}, {1'b0, 7'b0001001});
    chk("hold_pcard3", {4'd0, pcard3_out}, 8'd13);
    chk_scores("hold", 4'd1, 4'd0);

    // Player 7, 8, 9 -> 24 mod 10 = 4
    advance(6);
    load_pcard1 = 1'b1; tick(); load_pcard1 = 1'b0;
    advance(1);
    load_pcard2 = 1'b1; tick(); load_pcard2 = 1'b0;
    advance(1);
    load_pcard3 = 1'b1; tick(); load_pcard3 = 1'b0;
    chk("p789_hex0", {1'b0, HEX0}, {1'b0, 7'b1111000});
    chk("p789_hex2", {1'b0, HEX2}, {1'b0, 7'b0010000});
    chk("p789_pcard3", {4'd0, pcard3_out}, 8'd9);
    settle();
    chk_scores("p789", 4'd4, 4'd0);

    // Advance and load on the same edge capture the old value (9)
    card_adv = 1'b1; load_dcard1 = 1'b1;
    tick();
    card_adv = 1'b0; load_dcard1 = 1'b0;
    chk("same_edge_hex3", {1'b0, HEX3}, {1'b0, 7'b0010000});
    load_dcard2 = 1'b1; tick(); load_dcard2 = 1'b0;
    chk("next_hex4", {1'b0, HEX4}, {1'b0, 7'b1000000});
    settle();
    chk_scores("same_edge", 4'd4, 4'd9);

    // Out-of-range deal value renders blank and scores zero, then recovers to 1
    force dut.new_card = 4'd15;
    load_all();
    release dut.new_card;
    chk_hex_all("c15", 7'b1111111);
    chk("c15_pcard3", {4'd0, pcard3_out}, 8'd15);
    settle();
    chk_scores("c15", 4'd0, 4'd0);
    advance(1);
    chk("c15_recover", {4'd0, dut.new_card}, 8'd1);

    // Reset mid-game beats simultaneous load and advance
    advance(2);
    load_all();
    chk("pre_rst_pcard3", {4'd0, pcard3_out}, 8'd3);
    reset = 1'b1; card_adv = 1'b1; set_loads(1'b1);
    tick();
    reset = 1'b0; card_adv = 1'b0; set_loads(1'b0);
    chk_hex_all("mid_rst", 7'b1111111);
    chk("mid_rst_pcard3", {4'd0, pcard3_out}, 8'd0);
    chk("mid_rst_new_card", {4'd0, dut.new_card}, 8'd1);
    chk_scores("mid_rst", 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
